regfile_operand_unit: RTL and testbench

- Integer register file with operand-source selection. It sits directly upstream of the single-cycle RV32I ALU and drives its A and B inputs.
- It holds x0..x31, provides two combinational read ports and one synchronous write port, and selects ALU operand B between register rs2 and the sign-extended immediate.
- It also exposes rs2 raw data for stores, plus a debug read port for the testbench and bring-up.

---
 rtl/regfile_operand_unit.sv | 59 +++++
 tb/tb_regfile_operand_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/regfile_operand_unit.sv
// RV32I integer register file (x0 hardwired to zero) with the ALU operand-B source mux.
// Reads are combinational and never bypass the write port, which keeps the single-cycle loop open.
module regfile_operand_unit #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   A3,
  input  logic            WE3,
  input  logic [XLEN-1:0] WD3,
  input  logic            ALUSrc,
  input  logic [XLEN-1:0] ImmExt,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  // x0 has no storage; entries start at index 1.
  logic [XLEN-1:0] r_regs [1:NREGS-1];
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic [XLEN-1:0] w_dbg;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (WE3 && (A3 != '0)) begin
      r_regs[A3] <= WD3;
    end
  end

  // Reads are forced to zero while rst is held, so outputs are defined before the first clear.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    w_dbg = '0;
    if (!rst) begin
      if (A1 != '0)       w_rd1 = r_regs[A1];
      if (A2 != '0)       w_rd2 = r_regs[A2];
      if (dbg_addr != '0) w_dbg = r_regs[dbg_addr];
    end
  end

  assign RD1      = w_rd1;
  assign RD2      = w_rd2;
  assign dbg_data = w_dbg;
  assign SrcA     = w_rd1;
  assign SrcB     = ALUSrc ? ImmExt : w_rd2;

endmodule

// File: tb/tb_regfile_operand_unit.sv
// Scoreboard bench: stimulus queues expected output values, a negedge monitor pops and compares.
module tb_regfile_operand_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  A1, A2, A3, dbg_addr;
  logic        WE3, ALUSrc;
  logic [31:0] WD3, ImmExt;
  logic [31:0] RD1, RD2, SrcA, SrcB, dbg_data;

  regfile_operand_unit #(.XLEN(32), .NREGS(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3),
    .ALUSrc(ALUSrc), .ImmExt(ImmExt), .RD1(RD1), .RD2(RD2), .SrcA(SrcA),
    .SrcB(SrcB), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;   // 0 RD1, 1 RD2, 2 SrcA, 3 SrcB, 4 dbg_data
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic expect_out(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    q.push_back(e);
  endtask

  // Inputs change #1 after a rising edge; the monitor samples on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        0:       act = RD1;
        1:       act = RD2;
        2:       act = SrcA;
        3:       act = SrcB;
        default: act = dbg_data;
      endcase
      n_checks++;
      if (act === e.val) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
    end
  end

  logic [31:0] model [0:31];

  initial begin
    rst = 1'b1; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
    ALUSrc = 1'b0; ImmExt = '0; dbg_addr = 5'd5;
    expect_out("reset_hold_dbg", 4, 32'h0);
    expect_out("reset_hold_rd1", 0, 32'h0);
    tick();

    // Reset clear, with a write presented in the reset cycle
    rst = 1'b0; WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF;
    tick();
    WE3 = 1'b0; dbg_addr = 5'd5;
    expect_out("x5_written", 4, 32'hDEADBEEF);
    tick();
    rst = 1'b1; WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h00001234;
    tick();
    rst = 1'b0; WE3 = 1'b0; A1 = 5'd7;
    expect_out("x7_after_reset", 0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0];
      expect_out($sformatf("reset_clear_x%0d", i), 4, 32'h0);
      tick();
    end

    // x0 hardwiring
    WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFFFFFF; A1 = 5'd0; A2 = 5'd0;
    expect_out("x0_rd1_same", 0, 32'h0);
    expect_out("x0_rd2_same", 1, 32'h0);
    expect_out("x0_srca_same", 2, 32'h0);
    tick();
    WE3 = 1'b0;
    expect_out("x0_rd1_next", 0, 32'h0);
    expect_out("x0_rd2_next", 1, 32'h0);
    expect_out("x0_srca_next", 2, 32'h0);
    tick();

    // Read-old-value rule
    WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h10;
    tick();
    A1 = 5'd3; A3 = 5'd3; WD3 = 32'h20; WE3 = 1'b1;
    expect_out("rd_old_value", 0, 32'h10);
    tick();
    WE3 = 1'b0;
    expect_out("rd_new_value", 0, 32'h20);
    tick();

    // Dual read and operand mux
    WE3 = 1'b1; A3 = 5'd1; WD3 = 32'h7;
    tick();
    A3 = 5'd2; WD3 = 32'hFFFFFFF9;
    tick();
    WE3 = 1'b0; A1 = 5'd1; A2 = 5'd2; ImmExt = 32'h00000800; ALUSrc = 1'b0;
    expect_out("mux_srca", 2, 32'h7);
    expect_out("mux_srcb_reg", 3, 32'hFFFFFFF9);
    expect_out("mux_rd1", 0, 32'h7);
    tick();
    ALUSrc = 1'b1;
    expect_out("mux_srcb_imm", 3, 32'h00000800);
    expect_out("mux_rd2_store", 1, 32'hFFFFFFF9);
    tick();
    ALUSrc = 1'b0;

    // WE3 gating
    WE3 = 1'b0; A3 = 5'd9; WD3 = 32'hAAAA5555;
    repeat (3) tick();
    dbg_addr = 5'd9;
    expect_out("we3_gating_x9", 4, 32'h0);
    tick();

    // Full sweep
    model[0] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      model[i] = i * 32'h01010101;
      WE3 = 1'b1; A3 = i[4:0]; WD3 = model[i];
      tick();
    end
    WE3 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      A1 = i[4:0]; A2 = 5'(31 - i); dbg_addr = i[4:0];
      expect_out($sformatf("sweep_rd1_x%0d", i), 0, model[i]);
      expect_out($sformatf("sweep_rd2_x%0d", 31 - i), 1, model[31 - i]);
      expect_out($sformatf("sweep_dbg_x%0d", i), 4, model[i]);
      tick();
    end

    // Mid-program reset erases everything
    rst = 1'b1; dbg_addr = 5'd31;
    expect_out("midrst_hold_dbg", 4, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 1; i < 32; i += 5) begin
      dbg_addr = i[4:0];
      expect_out($sformatf("midrst_clear_x%0d", i), 4, 32'h0);
      tick();
    end

    tick();
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
